// File: rtl/alu4_cmd_queue.sv
// alu4_cmd_queue
//   Command buffer and issue stage in front of the 4-bit ALU. Commands {A, b, op}
//   arrive over a valid/ready handshake, are buffered in a DEPTH-entry FIFO and
//   are issued one per cycle from a registered output stage that drives the ALU.
//   Total capacity is DEPTH + 1 (FIFO entries plus the output register).
//
// Ports
//   clk        in   1        clock, all state on posedge
//   rst_n      in   1        asynchronous active-low reset
//   flush      in   1        synchronous clear of all queued commands
//   in_valid   in   1        upstream command valid
//   in_ready   out  1        queue can accept a command (registered)
//   in_a/in_b  in   4        operands
//   in_op      in   3        ALU option code, passed unmodified
//   out_valid  out  1        out_* holds a command for the ALU
//   out_ready  in   1        ALU consumes the command this cycle
//   out_a/out_b out 4        registered operands
//   out_op     out  3        registered option
//   level      out  LW       commands held (FIFO entries + out_valid)
module alu4_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_a,
    input  logic [3:0]                   in_b,
    input  logic [2:0]                   in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   out_a,
    output logic [3:0]                   out_b,
    output logic [2:0]                   out_op,
    output logic [$clog2(DEPTH+2)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 2);

    // Storage and registered state
    logic [10:0]   r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_out_valid;
    logic [3:0]    r_out_a;
    logic [3:0]    r_out_b;
    logic [2:0]    r_out_op;
    logic [LW-1:0] r_level;
    logic          r_in_ready;

    // Next-state helpers
    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_push;
    logic          w_load;
    logic          w_fifo_rd;
    logic          w_bypass;
    logic          w_fifo_wr;
    logic          w_out_valid_nxt;
    logic [AW:0]   w_count_nxt;
    logic [LW-1:0] w_level_nxt;
    logic          w_in_ready_nxt;
    logic [10:0]   w_head;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == {(AW+1){1'b0}});
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    // in_ready is a register, so there is no combinational path from out_ready
    assign w_push  = in_valid & r_in_ready;
    assign w_load  = ~r_out_valid | out_ready;

    // Decide load source for the output stage and the resulting occupancy
    always_comb begin
        w_fifo_rd       = 1'b0;
        w_bypass        = 1'b0;
        w_fifo_wr       = 1'b0;
        w_out_valid_nxt = r_out_valid;
        if (w_load) begin
            w_fifo_rd       = ~w_empty;
            // Empty FIFO: a fresh command goes straight to the output register
            w_bypass        = w_empty & w_push;
            w_out_valid_nxt = ~w_empty | w_push;
        end else begin
            w_fifo_rd       = 1'b0;
            w_bypass        = 1'b0;
            w_out_valid_nxt = r_out_valid;
        end
        w_fifo_wr      = w_push & ~w_bypass;
        w_count_nxt    = w_count + {{AW{1'b0}}, w_fifo_wr} - {{AW{1'b0}}, w_fifo_rd};
        w_level_nxt    = LW'(w_count_nxt) + LW'(w_out_valid_nxt);
        w_in_ready_nxt = (w_count_nxt != (AW+1)'(DEPTH));
    end

    // Pointers, output stage, level and in_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= {(AW+1){1'b0}};
            r_rd_ptr    <= {(AW+1){1'b0}};
            r_out_valid <= 1'b0;
            r_out_a     <= 4'd0;
            r_out_b     <= 4'd0;
            r_out_op    <= 3'd0;
            r_level     <= {LW{1'b0}};
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            // Drop everything, including a push in this cycle; out_* data hold
            r_wr_ptr    <= {(AW+1){1'b0}};
            r_rd_ptr    <= {(AW+1){1'b0}};
            r_out_valid <= 1'b0;
            r_level     <= {LW{1'b0}};
            r_in_ready  <= 1'b1;
        end else begin
            if (w_fifo_wr) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_fifo_rd) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
                r_out_a  <= w_head[10:7];
                r_out_b  <= w_head[6:3];
                r_out_op <= w_head[2:0];
            end else if (w_bypass) begin
                r_out_a  <= in_a;
                r_out_b  <= in_b;
                r_out_op <= in_op;
            end
            r_out_valid <= w_out_valid_nxt;
            r_level     <= w_level_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 11'd0;
            end
        end else if (w_fifo_wr && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {in_a, in_b, in_op};
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_op    = r_out_op;
    assign level     = r_level;

endmodule

// File: tb/tb_alu4_cmd_queue.sv
module tb_alu4_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic [2:0] out_op;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    logic [10:0] sb[$];
    bit          mon_en     = 1'b0;
    bit          prev_stall = 1'b0;
    logic [10:0] prev_out;
    int          mon_sz;
    logic [10:0] mon_exp;

    always #5 clk = ~clk;

    alu4_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .level     (level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard of accepted commands, checked against every pop
    always @(negedge clk) begin
        if (mon_en) begin
            mon_sz = sb.size();
            check("level", 32'(level), 32'(mon_sz));
            check("out_valid", 32'(out_valid), 32'(mon_sz > 0));
            check("in_ready", 32'(in_ready), 32'(mon_sz <= DEPTH));
            if (prev_stall) begin
                check("stall_hold", 32'({out_a, out_b, out_op}), 32'(prev_out));
            end
            if (flush) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (mon_sz == 0) begin
                        failures++;
                        $display("FAIL pop_unexpected actual=%0h required=none", {out_a, out_b, out_op});
                    end else begin
                        mon_exp = sb.pop_front();
                        if ({out_a, out_b, out_op} !== mon_exp) begin
                            failures++;
                            $display("FAIL pop_data actual=%0h required=%0h", {out_a, out_b, out_op}, mon_exp);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back({in_a, in_b, in_op});
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {out_a, out_b, out_op};
            end
        end
    end

    initial begin
        // 1. reset with in_valid held high
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd2; in_op = 3'b101;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mon_en = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_a", 32'(out_a), 32'd9);
        check("t1_level", 32'(level), 32'd1);
        out_ready = 1'b1;
        cyc(2);

        // 2. single command through bypass
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5; in_op = 3'b000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_out_a", 32'(out_a), 32'd3);
        check("t2_out_b", 32'(out_b), 32'd5);
        check("t2_out_op", 32'(out_op), 32'd0);
        check("t2_level", 32'(level), 32'd1);
        cyc(2);

        // 3. fill while stalled, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = 4'(i + 8); in_op = 3'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_level_full", 32'(level), 32'd5);
        check("t3_in_ready_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t3_drain_a", 32'(out_a), 32'(k));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t3_empty_level", 32'(level), 32'd0);
        @(posedge clk); #1;

        // 4. steady stream, one in and one out per cycle
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = ~4'(i); in_op = 3'(i % 8);
            @(negedge clk);
            check("t4_level", 32'(level), (i == 0) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        cyc(2);

        // 5. flush with three queued and a simultaneous push
        out_ready = 1'b0;
        for (int i = 10; i <= 12; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = 4'd1; in_op = 3'd2;
            @(posedge clk); #1;
        end
        flush = 1'b1; in_valid = 1'b1; in_a = 4'd14;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        check("t5_out_a_hold", 32'(out_a), 32'd10);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd4; in_op = 3'd6; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_after_a", 32'(out_a), 32'd7);
        check("t5_after_level", 32'(level), 32'd1);
        cyc(2);

        // 6. random traffic against the scoreboard
        void'($urandom(32'd1234));
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a      = 4'($urandom);
            in_b      = 4'($urandom);
            in_op     = 3'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check("t6_drain_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("t6_final_level", 32'(level), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
